// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//   Byte handshake between a producer and the UART transmitter.
//
//   Signals
//     tx_data   producer -> transmitter   byte to send, sampled on handshake
//     tx_valid  producer -> transmitter   tx_data holds a byte to send
//     tx_ready  transmitter -> producer   a byte can be accepted this cycle
//
//   A transfer happens on a rising edge where tx_valid and tx_ready are both
//   high. The producer may drop tx_valid at any time without side effects.
//
//   Modports
//     master  the producer (drives tx_data/tx_valid)
//     slave   the transmitter (drives tx_ready)
// ---------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface : uart_tx_if

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serial UART transmitter. Accepts one byte over the valid/ready handshake
//   in bus and sends it on tx as a frame:
//     start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//     STOP_BITS stop bits (1).
//   Every bit lasts exactly CLKS_PER_BIT clock cycles.
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//     DATA_BITS     data bits per frame (5..9)
//     PARITY_EN     1 inserts a parity bit after the data bits
//     PARITY_ODD    0 even parity, 1 odd parity (only with PARITY_EN=1)
//     STOP_BITS     1 or 2 stop bits
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset
//     bus        byte handshake (tx_data, tx_valid in; tx_ready out)
//     tx         serial line, idles high
//     busy       a frame is in progress
//     done       one-cycle pulse in the cycle after the last stop bit
//
//   Timing
//     Handshake on edge E0 -> tx=0 (start bit) from the next cycle on.
//     A frame of N bits occupies N*CLKS_PER_BIT cycles; done and tx_ready
//     are high together in cycle N*CLKS_PER_BIT+1, so with tx_valid held
//     high the next frame starts N*CLKS_PER_BIT+1 cycles after the first.
//
//   All outputs come straight from flops, so tx cannot glitch.
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy,
  output logic     done
);

  // -------------------------------------------------------------------------
  // Parameter legality
  // -------------------------------------------------------------------------
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be 2 or greater");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if ((PARITY_EN != 0) && (PARITY_EN != 1)) begin : g_bad_parity_en
    $error("uart_tx: PARITY_EN must be 0 or 1");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  // -------------------------------------------------------------------------
  // Local constants
  // -------------------------------------------------------------------------
  // Cycle counter runs 0..CLKS_PER_BIT-1 inside each bit.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Bit index is shared by the data phase and the stop phase; the data
  // phase needs the wider range.
  localparam int BIT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_reg,    state_next;
  logic [CNT_W-1:0]     cnt_reg,      cnt_next;
  logic [BIT_W-1:0]     bit_idx_reg,  bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg,    shift_next;
  logic                 parity_reg,   parity_next;
  logic                 tx_reg,       tx_next;
  logic                 tx_ready_reg, tx_ready_next;
  logic                 busy_reg,     busy_next;
  logic                 done_reg,     done_next;

  logic                 handshake;
  logic                 bit_end;

  // A byte is taken only while the registered tx_ready is high, which is
  // exactly the IDLE cycles after the first post-reset edge.
  assign handshake = bus.tx_valid && tx_ready_reg;

  // Last cycle of the current serial bit.
  assign bit_end = (cnt_reg == CNT_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      tx_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      tx_ready_reg <= tx_ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  //
  // tx_next is the value the line must show during the cycle after this
  // edge, so every transition loads the level of the bit it enters.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    tx_ready_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next       = 1'b1;
        tx_ready_next = 1'b1;
        busy_next     = 1'b0;
        if (handshake) begin
          // Latch the byte and its parity now; later changes on tx_data
          // cannot reach the frame.
          shift_next    = bus.tx_data;
          parity_next   = (^bus.tx_data) ^ ODD_PARITY;
          cnt_next      = '0;
          bit_idx_next  = '0;
          state_next    = START;
          tx_next       = 1'b0;
          tx_ready_next = 1'b0;
          busy_next     = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx_reg == DATA_LAST) begin
            bit_idx_next = '0;
            if (HAS_PARITY) begin
              state_next = PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            // tx currently shows shift_reg[0]; the next bit is one up.
            bit_idx_next = bit_idx_reg + BIT_W'(1);
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = STOP;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx_reg == STOP_LAST) begin
            // Frame complete: done and tx_ready rise together so a held
            // tx_valid starts the next frame at the edge ending this cycle.
            bit_idx_next  = '0;
            state_next    = IDLE;
            done_next     = 1'b1;
            tx_ready_next = 1'b1;
            busy_next     = 1'b0;
          end else begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tx           = tx_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign bus.tx_ready = tx_ready_reg;

endmodule : uart_tx
